// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the servo PWM path (capture and generator).
// Latency: n/a (package only).
// Backpressure: n/a.
package pwm_pkg;

    // Default system clock and nominal servo frame rate.
    localparam int CLK_IN_HZ     = 50_000_000;
    localparam int FREQ_SERVO_HZ = 50;

    // One nominal PWM frame in system-clock cycles; the generator's duty input
    // and the capture's width output share this unit.
    localparam int TOTAL_PERIOD  = CLK_IN_HZ / FREQ_SERVO_HZ;

    // Loss-of-signal window: two nominal frames.
    localparam int TIMEOUT_DEF   = 2 * TOTAL_PERIOD;

    // 2^21 > 2_000_000, so the default counters cannot reach all-ones before timeout.
    localparam int COUNT_W_DEF   = 21;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

endpackage

// File: rtl/pwm_in_cond.sv
// PWM input conditioning: 2-FF synchronizer, optional glitch filter (PWM_CAPTURE_FILTER_EN).
// Latency: 2 cycles, plus FILTER_LEN cycles on every edge when the filter is compiled in.
// Backpressure: none; free-running level path.
//
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_pwm         : asynchronous PWM input
//   o_lvl         : conditioned (synchronized, optionally filtered) level
//   o_settled     : high once the pipeline holds only post-reset samples of i_pwm
module pwm_in_cond #(
    parameter int FILTER_LEN = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pwm,
    output logic o_lvl,
    output logic o_settled
);

    // Settling window covers the synchronizer, the filter (if present) and one
    // cycle of margin, so a level seen after o_settled is a real input level and
    // not a reset value.
    localparam int SETTLE = 3 + FILTER_LEN;
    localparam int SCW    = $clog2(SETTLE + 1);

    logic           r_sync1;
    logic           r_sync2;
    logic [SCW-1:0] r_settle_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pwm;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_settle_cnt <= '0;
        end else if (r_settle_cnt != SCW'(SETTLE)) begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
        end
    end

    assign o_settled = (r_settle_cnt == SCW'(SETTLE));

`ifdef PWM_CAPTURE_FILTER_EN
    // The filtered level follows the synchronized input only after it has held
    // the opposite value for FILTER_LEN consecutive cycles; any shorter excursion
    // clears the run counter.
    localparam int FCW = $clog2(FILTER_LEN + 1);

    logic           r_filt;
    logic [FCW-1:0] r_run_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_filt    <= 1'b0;
            r_run_cnt <= '0;
        end else if (r_sync2 == r_filt) begin
            r_run_cnt <= '0;
        end else if (r_run_cnt == FCW'(FILTER_LEN - 1)) begin
            r_filt    <= r_sync2;
            r_run_cnt <= '0;
        end else begin
            r_run_cnt <= r_run_cnt + 1'b1;
        end
    end

    assign o_lvl = r_filt;
`else
    assign o_lvl = r_sync2;
`endif

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rise-to-rise period in clk cycles, flags loss of signal.
// Latency: sample_valid 3 clk edges after pwm_in is first sampled high (+FILTER_LEN with filter).
// Backpressure: none; sample_valid is a single-cycle pulse, width/period hold until the next sample.
//
// Optional feature macro: PWM_CAPTURE_FILTER_EN (glitch filter in pwm_in_cond).
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   pwm_in         : asynchronous PWM input
//   width, period  : last complete high time / period, in cycles
//   sample_valid   : one-cycle pulse when width/period update
//   timeout        : one-cycle pulse on loss of signal
//   signal_ok      : high from first sample until timeout or reset
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CLK_IN         = CLK_IN_HZ,
    parameter int FREQ_SERVO     = FREQ_SERVO_HZ,
    parameter int TIMEOUT_CYCLES = 2 * CLK_IN / FREQ_SERVO,
    parameter int COUNT_W        = COUNT_W_DEF,
    parameter int FILTER_LEN     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pwm_in,
    output logic [COUNT_W-1:0] width,
    output logic [COUNT_W-1:0] period,
    output logic               sample_valid,
    output logic               timeout,
    output logic               signal_ok
);

    localparam logic [COUNT_W-1:0] TO_LIM = COUNT_W'(TIMEOUT_CYCLES);

    // Counters stick at all-ones instead of wrapping if TIMEOUT_CYCLES does not
    // fit in COUNT_W.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic w_s;
    logic w_settled;
    logic r_s_d;
    logic w_rise;
    logic w_fall;
    logic r_armed;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [COUNT_W-1:0] r_hi_cnt;
    logic [COUNT_W-1:0] w_hi_nxt;
    logic [COUNT_W-1:0] r_per_cnt;
    logic [COUNT_W-1:0] w_per_nxt;
    logic [COUNT_W-1:0] r_width;
    logic [COUNT_W-1:0] w_width_nxt;
    logic [COUNT_W-1:0] r_period;
    logic [COUNT_W-1:0] w_period_nxt;
    logic               r_sample_valid;
    logic               w_sv_nxt;
    logic               r_timeout;
    logic               w_to_nxt;
    logic               r_signal_ok;
    logic               w_ok_nxt;

    pwm_in_cond #(
        .FILTER_LEN (FILTER_LEN)
    ) u_in_cond (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_pwm     (pwm_in),
        .o_lvl     (w_s),
        .o_settled (w_settled)
    );

    assign w_rise = w_s & ~r_s_d;
    assign w_fall = ~w_s & r_s_d;

    // The synchronizer resets low, so an input already high at reset would look
    // like a rising edge. Rises are only accepted once a genuine low level has
    // been seen, which discards a pulse that was in progress at reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_d   <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_s_d <= w_s;
            if (w_settled && !w_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_hi_nxt     = r_hi_cnt;
        w_per_nxt    = r_per_cnt;
        w_width_nxt  = r_width;
        w_period_nxt = r_period;
        w_sv_nxt     = 1'b0;
        w_to_nxt     = 1'b0;
        w_ok_nxt     = r_signal_ok;

        case (r_state)
            IDLE: begin
                if (w_rise && r_armed) begin
                    w_state_nxt = HIGH;
                    w_hi_nxt    = COUNT_W'(1);
                    w_per_nxt   = COUNT_W'(1);
                end
            end

            HIGH: begin
                if (w_fall) begin
                    w_state_nxt = LOW;
                    w_per_nxt   = sat_inc(r_per_cnt);
                end else if (r_per_cnt >= TO_LIM) begin
                    w_state_nxt = IDLE;
                    w_to_nxt    = 1'b1;
                    w_ok_nxt    = 1'b0;
                end else begin
                    w_hi_nxt  = sat_inc(r_hi_cnt);
                    w_per_nxt = sat_inc(r_per_cnt);
                end
            end

            LOW: begin
                // The rise is checked first: a rise landing on the timeout
                // cycle still closes a valid period.
                if (w_rise) begin
                    w_state_nxt  = HIGH;
                    w_width_nxt  = r_hi_cnt;
                    w_period_nxt = r_per_cnt;
                    w_sv_nxt     = 1'b1;
                    w_ok_nxt     = 1'b1;
                    w_hi_nxt     = COUNT_W'(1);
                    w_per_nxt    = COUNT_W'(1);
                end else if (r_per_cnt >= TO_LIM) begin
                    w_state_nxt = IDLE;
                    w_to_nxt    = 1'b1;
                    w_ok_nxt    = 1'b0;
                end else begin
                    w_per_nxt = sat_inc(r_per_cnt);
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_hi_cnt       <= '0;
            r_per_cnt      <= '0;
            r_width        <= '0;
            r_period       <= '0;
            r_sample_valid <= 1'b0;
            r_timeout      <= 1'b0;
            r_signal_ok    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_hi_cnt       <= w_hi_nxt;
            r_per_cnt      <= w_per_nxt;
            r_width        <= w_width_nxt;
            r_period       <= w_period_nxt;
            r_sample_valid <= w_sv_nxt;
            r_timeout      <= w_to_nxt;
            r_signal_ok    <= w_ok_nxt;
        end
    end

    assign width        = r_width;
    assign period       = r_period;
    assign sample_valid = r_sample_valid;
    assign timeout      = r_timeout;
    assign signal_ok    = r_signal_ok;

endmodule
